snoop_bus_arbiter: RTL and testbench
====================================

Name: snoop_bus_arbiter

Overview:
Arbitrates the shared 10-bit snooping bus between the three cache/CPU units of the snooping coherence system. It selects one requester round-robin, latches that requester's bus message and broadcasts it for one cycle. It then enables the two other CPUs as listeners and collects their snoop acknowledgements and shared indications. Finally it returns a completion pulse, the OR'd shared result and a timeout flag to the winner. It replaces fixed-step sequencing of the bus with a request/grant handshake.

Parameters:
MSG_W, 10, width of one bus message
TIMEOUT, 8, max cycles spent in SNOOP before forced completion (1..255)

Ports:
clock  input  1  system clock, all logic on rising edge
clear  input  1  synchronous active-high reset
req  input  3  bus request, bit i = CPU i; level, held until done
msg_in  input  3*MSG_W  message per CPU; CPU i at bits [i*MSG_W +: MSG_W]
snoop_ack  input  3  listener i finished snooping current message
snoop_shared  input  3  listener i holds the tag; valid when snoop_ack[i]=1
grant  output  3  one-hot owner of bus, 0 when idle
bus  output  MSG_W  broadcast message
bus_valid  output  1  bus carries a new message this cycle
listen_en  output  3  enables snoop logic of non-granted CPUs
done  output  1  one-cycle completion pulse to granted CPU
shared  output  1  OR of collected snoop_shared; valid with done
timeout  output  1  set with done if not all listeners acked
busy  output  1  state != IDLE

Behaviour:
- Reset (clock edge with clear=1): state=IDLE, grant=0, bus=0, bus_valid=0, listen_en=0, done=0, shared=0, timeout=0, busy=0, last_winner=2 (CPU0 has top priority first), ack_mask=0, shr_acc=0, timer=0. clear overrides all other inputs. Clear mid-transaction aborts it with no done pulse.
- States: IDLE, GRANT, BCAST, SNOOP, DONE.
- IDLE: if req!=0, pick the first set bit searching from (last_winner+1) mod 3 upward with wrap. Register grant one-hot, then go to GRANT. If req=0, stay.
- GRANT (1 cycle): bus <= msg_in slice of winner. Go to BCAST.
- BCAST (1 cycle): bus_valid=1. listen_en <= ~grant. Clear ack_mask, shr_acc and timer. Go to SNOOP.
- SNOOP: each cycle, ack_mask |= snoop_ack & listen_en, and shr_acc |= snoop_ack & listen_en & snoop_shared. Acks from the granted CPU are ignored.
  - Exit to DONE when (ack_mask | new acks) covers listen_en, or when timer == TIMEOUT-1. timer increments each SNOOP cycle.
  - Acks that arrive in the same cycle as the timeout are still counted.
- DONE (1 cycle): done=1, shared=|shr_acc, timeout=1 iff the listener mask is incomplete. listen_en<=0, last_winner<=winner index, then go to IDLE. grant stays asserted through DONE and clears on entry to IDLE.
- Registered outputs: shared and timeout hold until the next DONE. bus holds its last message. bus_valid and done are single-cycle pulses.
- Latency: req seen in IDLE at cycle 0 -> grant at cycle 1 -> bus_valid at cycle 2 -> SNOOP from cycle 3. With all acks in cycle 3, done is at cycle 4. Minimum turnaround is 5 cycles per transaction.
- Handshake:
  - A winner must drop req in the cycle after done. A req still high in IDLE is a new request, but round-robin serves other pending CPUs first.
  - req changes outside IDLE are ignored.
  - msg_in is sampled only in GRANT.
- Simultaneous requests are resolved purely by rotation; there is no starvation. With all three requesting continuously, grants go 0,1,2,0,...
- Unused snoop_ack/snoop_shared bits (the granted CPU, or outside SNOOP) have no effect.

Test Plan:
- Reset then req=3'b001, msg0=10'b0011010000, listeners 1 and 2 ack at cycle 3 with shared=3'b100 -> grant=001 at cycle 1, bus=0x0D0 with bus_valid at cycle 2, listen_en=110, done at cycle 4, shared=1, timeout=0.
- req=3'b111 held continuously, acks immediate -> grant sequence 001,010,100,001; each done 5 cycles apart.
- CPU2 granted, CPU0 acks at cycle 3 with shared=0, CPU1 never acks, TIMEOUT=8 -> done at cycle 3+8=11, timeout=1, shared=0.
- CPU1 granted, snoop_ack=3'b010 asserted by the granted CPU only -> ignored; listeners 0 and 2 ack a cycle later -> done one cycle after their ack, shared from listeners only.
- clear asserted during SNOOP -> next cycle all outputs 0, no done; req=100 afterwards -> grant=100 in 1 cycle, last_winner behaves as after reset.
- Acks spread over cycles (CPU0 at cycle 3 with shared=1, CPU2 at cycle 5 with shared=0) -> done at cycle 6, shared=1 (accumulated), timeout=0.

Source files
------------

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter for the shared snooping bus: grants one of three CPUs,
// broadcasts its message, collects listener acks/shared flags and reports completion.
module snoop_bus_arbiter #(
  parameter int unsigned MSG_W   = 10,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [2:0]         req,
  input  logic [3*MSG_W-1:0] msg_in,
  input  logic [2:0]         snoop_ack,
  input  logic [2:0]         snoop_shared,
  output logic [2:0]         grant,
  output logic [MSG_W-1:0]   bus,
  output logic               bus_valid,
  output logic [2:0]         listen_en,
  output logic               done,
  output logic               shared,
  output logic               timeout,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_BCAST,
    S_SNOOP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [MSG_W-1:0] bus_q, bus_d;
  logic             bus_valid_q, bus_valid_d;
  logic [2:0]       listen_q, listen_d;
  logic             done_q, done_d;
  logic             shared_q, shared_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       last_q, last_d;
  logic [2:0]       ack_q, ack_d;
  logic [2:0]       shr_q, shr_d;
  logic [7:0]       timer_q, timer_d;

  logic [2:0]       pick_oh;
  logic [1:0]       widx;
  logic [MSG_W-1:0] msg_sel;
  logic [2:0]       new_ack;
  logic [2:0]       new_shr;
  logic             covered;

  // Search starts just after the previous winner and wraps.
  always_comb begin
    pick_oh = '0;
    unique case (last_q)
      2'd0: begin
        if      (req[1]) pick_oh = 3'b010;
        else if (req[2]) pick_oh = 3'b100;
        else if (req[0]) pick_oh = 3'b001;
      end
      2'd1: begin
        if      (req[2]) pick_oh = 3'b100;
        else if (req[0]) pick_oh = 3'b001;
        else if (req[1]) pick_oh = 3'b010;
      end
      default: begin
        if      (req[0]) pick_oh = 3'b001;
        else if (req[1]) pick_oh = 3'b010;
        else if (req[2]) pick_oh = 3'b100;
      end
    endcase
  end

  always_comb begin
    widx    = grant_q[2] ? 2'd2 : (grant_q[1] ? 2'd1 : 2'd0);
    msg_sel = grant_q[2] ? msg_in[2*MSG_W +: MSG_W] :
              grant_q[1] ? msg_in[MSG_W +: MSG_W]   :
                           msg_in[0 +: MSG_W];
    new_ack = snoop_ack & listen_q;
    new_shr = new_ack & snoop_shared;
    covered = ((ack_q | new_ack) & listen_q) == listen_q;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    bus_d       = bus_q;
    bus_valid_d = 1'b0;
    listen_d    = listen_q;
    done_d      = 1'b0;
    shared_d    = shared_q;
    timeout_d   = timeout_q;
    last_d      = last_q;
    ack_d       = ack_q;
    shr_d       = shr_q;
    timer_d     = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = pick_oh;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        bus_d       = msg_sel;
        bus_valid_d = 1'b1;
        state_d     = S_BCAST;
      end
      S_BCAST: begin
        listen_d = ~grant_q;
        ack_d    = '0;
        shr_d    = '0;
        timer_d  = '0;
        state_d  = S_SNOOP;
      end
      S_SNOOP: begin
        ack_d   = ack_q | new_ack;
        shr_d   = shr_q | new_shr;
        timer_d = timer_q + 8'd1;
        // done/shared/timeout are registered here so they appear during DONE.
        if (covered || (timer_q == 8'(TIMEOUT - 1))) begin
          done_d    = 1'b1;
          shared_d  = |(shr_q | new_shr);
          timeout_d = ~covered;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        listen_d = '0;
        last_d   = widx;
        grant_d  = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      bus_q       <= '0;
      bus_valid_q <= 1'b0;
      listen_q    <= '0;
      done_q      <= 1'b0;
      shared_q    <= 1'b0;
      timeout_q   <= 1'b0;
      last_q      <= 2'd2;
      ack_q       <= '0;
      shr_q       <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      bus_q       <= bus_d;
      bus_valid_q <= bus_valid_d;
      listen_q    <= listen_d;
      done_q      <= done_d;
      shared_q    <= shared_d;
      timeout_q   <= timeout_d;
      last_q      <= last_d;
      ack_q       <= ack_d;
      shr_q       <= shr_d;
      timer_q     <= timer_d;
    end
  end

  assign grant     = grant_q;
  assign bus       = bus_q;
  assign bus_valid = bus_valid_q;
  assign listen_en = listen_q;
  assign done      = done_q;
  assign shared    = shared_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter: expected completions are queued when
// requests are driven and matched against every observed done pulse.
module tb_snoop_bus_arbiter;

  localparam int unsigned MSG_W = 10;
  localparam int unsigned TMO   = 8;
  localparam logic [9:0]  M0    = 10'h0D0;
  localparam logic [9:0]  M1    = 10'h155;
  localparam logic [9:0]  M2    = 10'h3A5;

  logic             clock = 1'b0;
  logic             clear;
  logic [2:0]       req;
  logic [3*MSG_W-1:0] msg_in;
  logic [2:0]       snoop_ack;
  logic [2:0]       snoop_shared;
  logic [2:0]       grant;
  logic [MSG_W-1:0] bus;
  logic             bus_valid;
  logic [2:0]       listen_en;
  logic             done;
  logic             shared;
  logic             timeout;
  logic             busy;

  snoop_bus_arbiter #(.MSG_W(MSG_W), .TIMEOUT(TMO)) dut (
    .clock(clock), .clear(clear), .req(req), .msg_in(msg_in),
    .snoop_ack(snoop_ack), .snoop_shared(snoop_shared),
    .grant(grant), .bus(bus), .bus_valid(bus_valid), .listen_en(listen_en),
    .done(done), .shared(shared), .timeout(timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  g;
    logic [9:0]  b;
    logic        sh;
    logic        to;
    int unsigned c;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int unsigned cyc = 0;
  int ntests = 0;
  int nfail  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Record every done pulse with the cycle it appeared in.
  always @(posedge clock) begin
    #2;
    if (done === 1'b1) obs_q.push_back({grant, bus, shared, timeout, cyc});
  end

  task automatic wait_obs(input int budget, output txn_t o, output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    ok = (obs_q.size() != 0);
    o  = ok ? obs_q.pop_front() : '0;
  endtask

  task automatic test_reset();
    clear = 1'b1; req = '0; snoop_ack = '0; snoop_shared = '0;
    msg_in = {M2, M1, M0};
    repeat (2) @(negedge clock);
    ntests++;
    if ({grant, bus, bus_valid, listen_en, done, shared, timeout, busy} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: grant=%b bus=%h bv=%b listen=%b done=%b sh=%b to=%b busy=%b, required all 0",
               grant, bus, bus_valid, listen_en, done, shared, timeout, busy);
    end
    clear = 1'b0;
  endtask

  task automatic test_basic();
    txn_t e, o; bit ok; int unsigned k;
    req = 3'b001; k = cyc;
    exp_q.push_back({3'b001, M0, 1'b1, 1'b0, k + 4});
    @(negedge clock);
    ntests++;
    if (grant !== 3'b001 || busy !== 1'b1 || bus_valid !== 1'b0) begin
      nfail++;
      $display("FAIL basic_grant: grant=%b busy=%b bv=%b, required 001 1 0", grant, busy, bus_valid);
    end
    @(negedge clock);
    ntests++;
    if (bus !== M0 || bus_valid !== 1'b1) begin
      nfail++;
      $display("FAIL basic_bcast: bus=%h bv=%b, required %h 1", bus, bus_valid, M0);
    end
    @(negedge clock);
    ntests++;
    if (listen_en !== 3'b110 || bus_valid !== 1'b0) begin
      nfail++;
      $display("FAIL basic_listen: listen=%b bv=%b, required 110 0", listen_en, bus_valid);
    end
    snoop_ack = 3'b110; snoop_shared = 3'b100;
    wait_obs(20, o, ok);
    e = exp_q.pop_front();
    ntests++;
    if (!ok || o !== e) begin
      nfail++;
      $display("FAIL basic_txn: got ok=%b g=%b bus=%h sh=%b to=%b cyc=%0d, required g=%b bus=%h sh=%b to=%b cyc=%0d",
               ok, o.g, o.b, o.sh, o.to, o.c, e.g, e.b, e.sh, e.to, e.c);
    end
    req = '0; snoop_ack = '0; snoop_shared = '0;
    @(negedge clock);
    ntests++;
    if (grant !== 3'b000 || done !== 1'b0 || shared !== 1'b1 || listen_en !== 3'b000 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL basic_after: grant=%b done=%b sh=%b listen=%b busy=%b, required 000 0 1 000 0",
               grant, done, shared, listen_en, busy);
    end
  endtask

  task automatic test_round_robin();
    txn_t e, o; bit ok; int unsigned k;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    req = 3'b111; snoop_ack = 3'b111; snoop_shared = 3'b001; k = cyc;
    exp_q.push_back({3'b001, M0, 1'b0, 1'b0, k + 4});
    exp_q.push_back({3'b010, M1, 1'b1, 1'b0, k + 9});
    exp_q.push_back({3'b100, M2, 1'b1, 1'b0, k + 14});
    exp_q.push_back({3'b001, M0, 1'b0, 1'b0, k + 19});
    for (int i = 0; i < 4; i++) begin
      wait_obs(12, o, ok);
      e = exp_q.pop_front();
      ntests++;
      if (!ok || o !== e) begin
        nfail++;
        $display("FAIL rr_txn%0d: got ok=%b g=%b bus=%h sh=%b to=%b cyc=%0d, required g=%b bus=%h sh=%b to=%b cyc=%0d",
                 i, ok, o.g, o.b, o.sh, o.to, o.c, e.g, e.b, e.sh, e.to, e.c);
      end
    end
    req = '0; snoop_ack = '0; snoop_shared = '0;
    @(negedge clock);
  endtask

  task automatic test_timeout();
    txn_t e, o; bit ok; int unsigned k;
    req = 3'b100; k = cyc;
    exp_q.push_back({3'b100, M2, 1'b0, 1'b1, k + 3 + TMO});
    repeat (3) @(negedge clock);
    snoop_ack = 3'b001; snoop_shared = 3'b110;
    @(negedge clock);
    snoop_ack = '0; snoop_shared = '0; req = '0;
    wait_obs(20, o, ok);
    e = exp_q.pop_front();
    ntests++;
    if (!ok || o !== e) begin
      nfail++;
      $display("FAIL timeout_txn: got ok=%b g=%b bus=%h sh=%b to=%b cyc=%0d, required g=%b bus=%h sh=%b to=%b cyc=%0d",
               ok, o.g, o.b, o.sh, o.to, o.c, e.g, e.b, e.sh, e.to, e.c);
    end
    repeat (2) @(negedge clock);
    ntests++;
    if (timeout !== 1'b1 || shared !== 1'b0 || bus !== M2 || done !== 1'b0 || grant !== 3'b000) begin
      nfail++;
      $display("FAIL timeout_hold: to=%b sh=%b bus=%h done=%b grant=%b, required 1 0 %h 0 000",
               timeout, shared, bus, done, grant, M2);
    end
  endtask

  task automatic test_granted_ack();
    txn_t e, o; bit ok; int unsigned k;
    req = 3'b010; k = cyc;
    exp_q.push_back({3'b010, M1, 1'b0, 1'b0, k + 5});
    repeat (3) @(negedge clock);
    ntests++;
    if (listen_en !== 3'b101) begin
      nfail++;
      $display("FAIL gack_listen: listen=%b, required 101", listen_en);
    end
    snoop_ack = 3'b010; snoop_shared = 3'b010;
    @(negedge clock);
    snoop_ack = 3'b101; snoop_shared = 3'b000;
    wait_obs(20, o, ok);
    e = exp_q.pop_front();
    ntests++;
    if (!ok || o !== e) begin
      nfail++;
      $display("FAIL gack_txn: got ok=%b g=%b bus=%h sh=%b to=%b cyc=%0d, required g=%b bus=%h sh=%b to=%b cyc=%0d",
               ok, o.g, o.b, o.sh, o.to, o.c, e.g, e.b, e.sh, e.to, e.c);
    end
    req = '0; snoop_ack = '0; snoop_shared = '0;
    @(negedge clock);
  endtask

  task automatic test_clear_mid();
    txn_t e, o; bit ok; int unsigned k;
    req = 3'b001;
    repeat (3) @(negedge clock);
    ntests++;
    if (busy !== 1'b1 || grant !== 3'b001) begin
      nfail++;
      $display("FAIL clear_pre: busy=%b grant=%b, required 1 001", busy, grant);
    end
    clear = 1'b1; snoop_ack = 3'b110; snoop_shared = 3'b110;
    @(negedge clock);
    ntests++;
    if ({grant, bus, bus_valid, listen_en, done, shared, timeout, busy} !== '0) begin
      nfail++;
      $display("FAIL clear_outputs: grant=%b bus=%h bv=%b listen=%b done=%b sh=%b to=%b busy=%b, required all 0",
               grant, bus, bus_valid, listen_en, done, shared, timeout, busy);
    end
    clear = 1'b0; snoop_ack = '0; snoop_shared = '0; req = 3'b100; k = cyc;
    exp_q.push_back({3'b100, M2, 1'b0, 1'b0, k + 4});
    @(negedge clock);
    ntests++;
    if (grant !== 3'b100) begin
      nfail++;
      $display("FAIL clear_regrant: grant=%b, required 100", grant);
    end
    repeat (2) @(negedge clock);
    snoop_ack = 3'b011;
    wait_obs(20, o, ok);
    e = exp_q.pop_front();
    ntests++;
    if (!ok || o !== e) begin
      nfail++;
      $display("FAIL clear_txn: got ok=%b g=%b bus=%h sh=%b to=%b cyc=%0d, required g=%b bus=%h sh=%b to=%b cyc=%0d",
               ok, o.g, o.b, o.sh, o.to, o.c, e.g, e.b, e.sh, e.to, e.c);
    end
    req = '0; snoop_ack = '0;
    @(negedge clock);
  endtask

  task automatic test_spread();
    txn_t e, o; bit ok; int unsigned k;
    req = 3'b010; k = cyc;
    exp_q.push_back({3'b010, M1, 1'b1, 1'b0, k + 6});
    repeat (3) @(negedge clock);
    snoop_ack = 3'b001; snoop_shared = 3'b001;
    @(negedge clock);
    snoop_ack = 3'b000; snoop_shared = 3'b000;
    @(negedge clock);
    snoop_ack = 3'b100; snoop_shared = 3'b000;
    wait_obs(20, o, ok);
    e = exp_q.pop_front();
    ntests++;
    if (!ok || o !== e) begin
      nfail++;
      $display("FAIL spread_txn: got ok=%b g=%b bus=%h sh=%b to=%b cyc=%0d, required g=%b bus=%h sh=%b to=%b cyc=%0d",
               ok, o.g, o.b, o.sh, o.to, o.c, e.g, e.b, e.sh, e.to, e.c);
    end
    req = '0; snoop_ack = '0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_granted_ack();
    test_clear_mid();
    test_spread();
    repeat (3) @(negedge clock);
    ntests++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      nfail++;
      $display("FAIL stray_done: observed left=%0d expected left=%0d, required 0 0",
               obs_q.size(), exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
